// File: rtl/hermes_vc_buffer.sv
// hermes_vc_buffer: multi-VC Hermes input buffer forwarding whole packets round-robin to one output
module hermes_vc_buffer #(
  parameter int VC_COUNT    = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 32,
  localparam int VC_W       = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [VC_W-1:0]      vc_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic [VC_COUNT-1:0]  credit_o,
  output logic                 req_o,
  input  logic                 req_ack_i,
  output logic [VC_W-1:0]      vc_o,
  output logic                 data_av_o,
  input  logic                 data_ack_i,
  output logic                 sending_o,
  output logic [FLIT_SIZE-1:0] data_o
);
  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    REQ     = 5'b00010,
    HEADER  = 5'b00100,
    SIZE    = 5'b01000,
    PAYLOAD = 5'b10000
  } state_t;
  logic [FLIT_SIZE-1:0] mem_q [VC_COUNT][BUFFER_SIZE];
  logic [FLIT_SIZE-1:0] mem_d [VC_COUNT][BUFFER_SIZE];
  logic [PTR_W-1:0]     wr_ptr_q [VC_COUNT], wr_ptr_d [VC_COUNT];
  logic [PTR_W-1:0]     rd_ptr_q [VC_COUNT], rd_ptr_d [VC_COUNT];
  logic [CNT_W-1:0]     count_q [VC_COUNT], count_d [VC_COUNT];
  state_t               state_q, state_d;
  logic [VC_W-1:0]      sel_q, sel_d, last_q, last_d, pick;
  logic [FLIT_SIZE-1:0] flit_cnt_q, flit_cnt_d;
  logic                 found, xfer, wr, rd;
  int                   idx;
  always_comb begin
    data_av_o = (state_q inside {HEADER, SIZE, PAYLOAD}) && count_q[sel_q] != '0;
    data_o    = data_av_o ? mem_q[sel_q][rd_ptr_q[sel_q]] : '0;
    sending_o = data_av_o;
    xfer      = data_av_o && data_ack_i;
    req_o     = state_q == REQ;
    vc_o      = state_q == IDLE ? '0 : sel_q;
  end
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_o = '0;
    wr       = 1'b0;
    rd       = 1'b0;
    for (int v = 0; v < VC_COUNT; v++) begin
      credit_o[v] = count_q[v] < CNT_W'(BUFFER_SIZE);
      wr = rx_i && vc_i == VC_W'(v) && credit_o[v];
      rd = xfer && sel_q == VC_W'(v);
      if (wr) begin
        mem_d[v][wr_ptr_q[v]] = data_i;
        wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
      end
      if (rd) rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
      count_d[v] = count_q[v] + CNT_W'(wr) - CNT_W'(rd);
    end
  end
  // Walk downward so the VC closest after last_q is the one left in pick.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = VC_COUNT; i >= 1; i--) begin
      idx = (int'(last_q) + i) % VC_COUNT;
      if (count_q[idx] != '0) begin
        pick  = VC_W'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    flit_cnt_d = flit_cnt_q;
    case (state_q)
      IDLE: if (found) begin
        sel_d   = pick;
        state_d = REQ;
      end
      REQ:     state_d = req_ack_i ? HEADER : REQ;
      HEADER:  state_d = xfer ? SIZE : HEADER;
      SIZE: if (xfer) begin
        flit_cnt_d = data_o;
        state_d    = data_o == '0 ? IDLE : PAYLOAD;
      end
      PAYLOAD: if (xfer) begin
        flit_cnt_d = flit_cnt_q - FLIT_SIZE'(1);
        state_d    = flit_cnt_q == FLIT_SIZE'(1) ? IDLE : PAYLOAD;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE && state_q != IDLE) last_d = sel_q;
  end
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_ptr_q   <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      count_q    <= '{default: '0};
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= VC_W'(VC_COUNT - 1);
      flit_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end
  // Writing into a full VC is a sender protocol error; the flit is dropped.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (rx_i && int'(vc_i) < VC_COUNT) |-> credit_o[vc_i])
    else $warning("hermes_vc_buffer: flit dropped, vc %0d has no credit", vc_i);
endmodule

// File: tb/tb_hermes_vc_buffer.sv
// tb_hermes_vc_buffer: scoreboard bench for hermes_vc_buffer
module tb_hermes_vc_buffer;
  logic        clk_i = 0, rst_i = 1, rx_i = 0, req_ack_i = 0, data_ack_i = 0;
  logic [0:0]  vc_i = 0;
  logic [31:0] data_i = 0;
  logic [1:0]  credit_o;
  logic        req_o, data_av_o, sending_o;
  logic [0:0]  vc_o;
  logic [31:0] data_o;
  typedef struct {logic [0:0] vc; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
  int n_req = 0, req_wait = 0, r0 = 0;
  bit ack_en = 0;
  hermes_vc_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .vc_i(vc_i), .data_i(data_i),
    .credit_o(credit_o), .req_o(req_o), .req_ack_i(req_ack_i), .vc_o(vc_o),
    .data_av_o(data_av_o), .data_ack_i(data_ack_i), .sending_o(sending_o), .data_o(data_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input logic [0:0] v, input logic [31:0] d);
    rx_i = 1; vc_i = v; data_i = d;
    tick;
    rx_i = 0;
  endtask
  task automatic push(input logic [0:0] v, input logic [31:0] d);
    exp_t e;
    e.vc = v; e.d = d;
    exp_q.push_back(e);
  endtask
  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick;
      k++;
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask
  task automatic idle_chk(input string tag);
    @(negedge clk_i);
    chk({tag, "_req"}, req_o, 0);
    chk({tag, "_av"}, data_av_o, 0);
    chk({tag, "_vc"}, vc_o, 0);
  endtask
  // Output monitor: every flit taken must be the next scoreboard entry.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && data_av_o && data_ack_i) begin
      chk("sending", sending_o, 1);
      if (exp_q.size() == 0) chk("extra_flit_queue", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("flit_vc", vc_o, e.vc);
        chk("flit_data", data_o, e.d);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end
  // Router model: grants each request two cycles after it appears.
  always begin
    @(posedge clk_i);
    #1;
    if (!(ack_en && req_o)) begin
      req_wait = 0;
      req_ack_i = 0;
    end else if (!req_ack_i) begin
      req_wait++;
      if (req_wait >= 2) begin
        req_ack_i = 1;
        n_req++;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) tick;
    rst_i = 0;
    @(negedge clk_i);
    chk("rst_credit", credit_o, 2'b11);
    chk("rst_req", req_o, 0);
    chk("rst_av", data_av_o, 0);
    chk("rst_vc", vc_o, 0);
    chk("rst_data", data_o, 0);
    tick;
    ack_en = 1; data_ack_i = 1; first_cyc = -1;
    push(0, 32'h0102); push(0, 3); push(0, 32'hA); push(0, 32'hB); push(0, 32'hC);
    wr(0, 32'h0102); wr(0, 3); wr(0, 32'hA); wr(0, 32'hB); wr(0, 32'hC);
    drain("t2", 40);
    chk("t2_span", last_cyc - first_cyc, 4);
    tick;
    idle_chk("t2_end");
    chk("t2_credit0", credit_o[0], 1);
    tick;
    ack_en = 0; data_ack_i = 0;
    wr(1, 32'h1000); wr(1, 6);
    for (int i = 1; i <= 6; i++) wr(1, 32'h1000 + i);
    @(negedge clk_i);
    chk("t3_full", credit_o[1], 0);
    chk("t3_other", credit_o[0], 1);
    tick;
    wr(1, 32'h1FFF);
    @(negedge clk_i);
    chk("t3_drop_cnt", dut.count_q[1], 8);
    chk("t3_still_full", credit_o[1], 0);
    tick;
    ack_en = 1;
    for (int k = 0; k < 20 && !data_av_o; k++) tick;
    chk("t3_av", data_av_o, 1);
    push(1, 32'h1000);
    data_ack_i = 1;
    @(negedge clk_i);
    chk("t3_no_early_credit", credit_o[1], 0);
    tick;
    data_ack_i = 0;
    @(negedge clk_i);
    chk("t3_credit_back", credit_o[1], 1);
    tick;
    push(1, 6);
    for (int i = 1; i <= 6; i++) push(1, 32'h1000 + i);
    data_ack_i = 1;
    drain("t3", 40);
    repeat (3) tick;
    idle_chk("t3_end");
    tick;
    ack_en = 0; data_ack_i = 0;
    wr(0, 32'h0A00); wr(0, 1); wr(0, 32'hA1);
    wr(0, 32'h0B00); wr(0, 2); wr(0, 32'hB1); wr(0, 32'hB2);
    wr(1, 32'h1100); wr(1, 1); wr(1, 32'h11);
    push(0, 32'h0A00); push(0, 1); push(0, 32'hA1);
    push(1, 32'h1100); push(1, 1); push(1, 32'h11);
    push(0, 32'h0B00); push(0, 2); push(0, 32'hB1); push(0, 32'hB2);
    ack_en = 1; data_ack_i = 1;
    drain("t4", 80);
    tick;
    idle_chk("t4_end");
    tick;
    r0 = n_req;
    push(0, 32'h0203); push(0, 0); push(0, 32'h0304); push(0, 1); push(0, 32'hD);
    wr(0, 32'h0203); wr(0, 0); wr(0, 32'h0304); wr(0, 1); wr(0, 32'hD);
    drain("t5", 60);
    tick;
    chk("t5_reqs", n_req - r0, 2);
    idle_chk("t5_end");
    tick;
    push(0, 32'h0600); push(0, 4); push(0, 32'h61); push(0, 32'h62);
    wr(0, 32'h0600); wr(0, 4); wr(0, 32'h61); wr(0, 32'h62);
    drain("t6", 40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t6_stall_av", data_av_o, 0);
      chk("t6_stall_cnt", dut.flit_cnt_q, 2);
      tick;
    end
    rst_i = 1;
    tick;
    rst_i = 0;
    @(negedge clk_i);
    chk("t6_rst_credit", credit_o, 2'b11);
    chk("t6_rst_av", data_av_o, 0);
    chk("t6_rst_req", req_o, 0);
    chk("t6_rst_vc", vc_o, 0);
    tick;
    push(0, 32'h0700); push(0, 1); push(0, 32'h71);
    wr(0, 32'h0700); wr(0, 1); wr(0, 32'h71);
    drain("t6b", 40);
    tick;
    idle_chk("t6_end");
    chk("t6_credit", credit_o, 2'b11);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
